// File: rtl/rotary_level_scheduler_pkg.sv
// Shared definitions for the rotary level scheduler.
//   wr_state_e   : write FSM state encoding (ST_IDLE, ST_REQ)
//   DEF_*        : default channel count, level width and reset level
//   wrap_inc     : modulo increment used for channel/pointer wrap
package rotary_level_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } wr_state_e;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_LEVEL_W = 4;
  localparam int DEF_LEVEL   = 8;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rotary_level_scheduler_rr_dirty_picker.sv
// Combinational round-robin pick: returns the first set dirty bit at or
// after rr_ptr, wrapping modulo NUM_CH.
//   dirty  in   NUM_CH  per-channel pending-write flags
//   rr_ptr in   CH_W    channel with highest priority this cycle
//   pick   out  CH_W    selected channel (0 when nothing is dirty)
//   any    out  1       at least one dirty bit set
module rr_dirty_picker #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] dirty,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [CH_W-1:0]   pick,
  output logic              any
);

  int              idx;
  logic [CH_W-1:0] idx_c;

  // Scan from the farthest offset down to offset 0 so the nearest dirty
  // channel to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick  = '0;
    idx   = 0;
    idx_c = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_c = CH_W'(idx);
      if (dirty[idx_c]) pick = idx_c;
    end
    any = |dirty;
  end

endmodule

// File: rtl/rotary_level_scheduler.sv
// Rotary level scheduler: owns NUM_CH per-channel levels edited by one
// rotary encoder and pushes changed levels round-robin onto a req/ack bus.
//   clk, reset            clock, synchronous active-high reset
//   step_inc, step_dec    one-cycle step pulses for the selected channel
//   sel_btn               debounced select level; rising edge advances cur_ch
//   cur_ch, cur_level     selected channel and its current level
//   wr_req/addr/data      write request, held with stable addr/data until ack
//   wr_ack                target accepts when wr_req & wr_ack
//   busy                  write pending or any channel dirty
//
// Write FSM
//   state   | meaning
//   ST_IDLE | no transfer; latches a round-robin pick when anything is dirty
//   ST_REQ  | wr_req high, waiting for wr_ack with addr/data held
module rotary_level_scheduler
  import rotary_level_scheduler_pkg::*;
#(
  parameter  int NUM_CH        = DEF_NUM_CH,
  parameter  int LEVEL_W       = DEF_LEVEL_W,
  parameter  int DEFAULT_LEVEL = DEF_LEVEL,
  localparam int CH_W          = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_inc,
  input  logic               step_dec,
  input  logic               sel_btn,
  output logic [CH_W-1:0]    cur_ch,
  output logic [LEVEL_W-1:0] cur_level,
  output logic               wr_req,
  output logic [CH_W-1:0]    wr_addr,
  output logic [LEVEL_W-1:0] wr_data,
  input  logic               wr_ack,
  output logic               busy
);

  localparam logic [LEVEL_W-1:0] LVL_MAX = '1;
  localparam logic [LEVEL_W-1:0] LVL_DEF = LEVEL_W'(DEFAULT_LEVEL);

  logic [LEVEL_W-1:0] level_q [NUM_CH];
  logic [NUM_CH-1:0]  dirty_q, dirty_d, set_mask, clr_mask;
  logic [CH_W-1:0]    cur_ch_q, rr_ptr_q, wr_addr_q, pick;
  logic [LEVEL_W-1:0] wr_data_q, new_level;
  logic               sel_q, sel_edge, any_dirty;
  logic               do_inc, do_dec, chg;
  logic               latch, ack_fire;
  // stale: the channel in flight changed after its data was latched, so the
  // ack must not clear its dirty bit.
  logic               stale_q, stale_d;
  wr_state_e          state_q, state_d;

  assign cur_ch    = cur_ch_q;
  assign cur_level = level_q[cur_ch_q];
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_req    = (state_q == ST_REQ);
  assign busy      = wr_req | (|dirty_q);

  // Saturated or cancelling steps produce no change and no dirty mark.
  assign do_inc    = step_inc & ~step_dec & (cur_level != LVL_MAX);
  assign do_dec    = step_dec & ~step_inc & (cur_level != '0);
  assign chg       = do_inc | do_dec;
  assign new_level = do_inc ? cur_level + LEVEL_W'(1) : cur_level - LEVEL_W'(1);
  assign set_mask  = chg ? (NUM_CH'(1) << cur_ch_q) : '0;
  assign sel_edge  = sel_btn & ~sel_q;

  // Set wins over clear when a change and the ack land together.
  assign dirty_d   = (dirty_q & ~clr_mask) | set_mask;

  rr_dirty_picker #(.NUM_CH(NUM_CH)) u_picker (
    .dirty  (dirty_q),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .any    (any_dirty)
  );

  always_comb begin
    state_d  = state_q;
    stale_d  = stale_q;
    clr_mask = '0;
    latch    = 1'b0;
    ack_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_dirty) begin
          latch   = 1'b1;
          state_d = ST_REQ;
          stale_d = chg && (cur_ch_q == pick);
        end
      end
      ST_REQ: begin
        stale_d = stale_q | (chg && (cur_ch_q == wr_addr_q));
        if (wr_ack) begin
          ack_fire = 1'b1;
          state_d  = ST_IDLE;
          if (!stale_d) clr_mask = NUM_CH'(1) << wr_addr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) level_q[i] <= LVL_DEF;
      dirty_q   <= '1;
      cur_ch_q  <= '0;
      rr_ptr_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sel_q     <= 1'b0;
    end else begin
      if (chg) level_q[cur_ch_q] <= new_level;
      if (sel_edge) cur_ch_q <= CH_W'(wrap_inc(int'(cur_ch_q), NUM_CH));
      sel_q   <= sel_btn;
      dirty_q <= dirty_d;
      if (latch) begin
        wr_addr_q <= pick;
        wr_data_q <= level_q[pick];
      end
      if (ack_fire) rr_ptr_q <= CH_W'(wrap_inc(int'(wr_addr_q), NUM_CH));
    end
  end

endmodule

// File: tb/tb_rotary_level_scheduler.sv
// Directed bench for rotary_level_scheduler (NUM_CH=4, LEVEL_W=4, default 8).
// Completed writes are logged as addr*16+data and compared to hand-computed lists.
module tb_rotary_level_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_inc = 1'b0, step_dec = 1'b0, sel_btn = 1'b0, wr_ack = 1'b1;
  logic [1:0] cur_ch, wr_addr;
  logic [3:0] cur_level, wr_data;
  logic       wr_req, busy;

  int n_chk = 0;
  int n_pass = 0;
  int wlog[$];

  rotary_level_scheduler #(.NUM_CH(4), .LEVEL_W(4), .DEFAULT_LEVEL(8)) dut (
    .clk(clk), .reset(reset), .step_inc(step_inc), .step_dec(step_dec),
    .sel_btn(sel_btn), .cur_ch(cur_ch), .cur_level(cur_level),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && wr_req && wr_ack) wlog.push_back(int'(wr_addr) * 16 + int'(wr_data));

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  function automatic int wl(input int i);
    return (i < wlog.size()) ? wlog[i] : -1;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic inc, input logic dec);
    step_inc = inc; step_dec = dec;
    tick();
    step_inc = 1'b0; step_dec = 1'b0;
    tick();
  endtask

  task automatic press();
    sel_btn = 1'b1;
    tick();
    sel_btn = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || wr_req) && k < 60) begin
      tick();
      k++;
    end
    check(tag, int'(busy), 0);
  endtask

  task automatic check_log(input string tag, input int exp[$]);
    check({tag, "_n"}, wlog.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) check($sformatf("%s_%0d", tag, i), wl(i), exp[i]);
    wlog.delete();
  endtask

  initial begin
    // 1: reset state and full flush with wr_ack tied high
    tick(2);
    check("rst_wr_req", int'(wr_req), 0);
    check("rst_cur_ch", int'(cur_ch), 0);
    check("rst_level", int'(cur_level), 8);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    reset = 1'b0;
    wlog.delete();
    wait_idle("flush_idle");
    check_log("flush", '{8, 16 + 8, 32 + 8, 48 + 8});

    // 2: saturation on ch0
    repeat (7) pulse(1'b1, 1'b0);
    wait_idle("ramp_idle");
    wlog.delete();
    check("lvl_15", int'(cur_level), 15);
    repeat (3) pulse(1'b1, 1'b0);
    tick(4);
    check("sat_level", int'(cur_level), 15);
    check("sat_busy", int'(busy), 0);
    pulse(1'b1, 1'b1);
    tick(4);
    check("incdec_level", int'(cur_level), 15);
    check_log("sat", '{});
    pulse(1'b0, 1'b1);
    check("dec_level", int'(cur_level), 14);
    wait_idle("dec_idle");
    check_log("dec", '{14});

    // 3: select edges, wrap, held button
    press(); check("sel1", int'(cur_ch), 1);
    press(); check("sel2", int'(cur_ch), 2);
    press(); check("sel3", int'(cur_ch), 3);
    press(); check("sel0", int'(cur_ch), 0);
    sel_btn = 1'b1;
    tick(10);
    check("held_ch", int'(cur_ch), 1);
    sel_btn = 1'b0;
    tick();
    check("held_rel_ch", int'(cur_ch), 1);

    // 3/4: step in the edge cycle hits ch1; write held pending with no ack
    wr_ack = 1'b0;
    sel_btn = 1'b1; step_inc = 1'b1;
    tick();
    sel_btn = 1'b0; step_inc = 1'b0;
    tick();
    check("edge_step_ch", int'(cur_ch), 2);
    check("edge_step_ch2_lvl", int'(cur_level), 8);
    tick(3);
    check("pend_req", int'(wr_req), 1);
    check("pend_addr", int'(wr_addr), 1);
    check("pend_data", int'(wr_data), 9);
    repeat (3) press();
    check("back_ch1", int'(cur_ch), 1);
    check("ch1_lvl9", int'(cur_level), 9);
    pulse(1'b1, 1'b0);
    check("inflight_lvl", int'(cur_level), 10);
    check("inflight_data", int'(wr_data), 9);
    check("inflight_addr", int'(wr_addr), 1);
    check("inflight_req", int'(wr_req), 1);
    check_log("noack", '{});
    wr_ack = 1'b1;
    wait_idle("inflight_idle");
    check_log("inflight", '{16 + 9, 16 + 10});

    // 5: rr_ptr=1 after ch0 write, ch0 and ch2 both dirty -> ch2 first
    wr_ack = 1'b0;
    repeat (3) press();
    check("fair_ch0", int'(cur_ch), 0);
    pulse(1'b1, 1'b0);
    tick(3);
    check("fair_req_addr", int'(wr_addr), 0);
    check("fair_req_data", int'(wr_data), 15);
    pulse(1'b0, 1'b1);
    repeat (2) press();
    pulse(1'b1, 1'b0);
    check("fair_ch2_lvl", int'(cur_level), 9);
    wr_ack = 1'b1;
    wait_idle("fair_idle");
    check_log("fair", '{15, 32 + 9, 14});

    // 6: reset while a request is pending and unacknowledged
    wr_ack = 1'b0;
    pulse(1'b1, 1'b0);
    tick(3);
    check("mid_req", int'(wr_req), 1);
    check("mid_data", int'(wr_data), 10);
    reset = 1'b1;
    tick();
    check("mid_rst_req", int'(wr_req), 0);
    check("mid_rst_ch", int'(cur_ch), 0);
    check("mid_rst_lvl", int'(cur_level), 8);
    reset = 1'b0;
    wr_ack = 1'b1;
    wlog.delete();
    wait_idle("reflush_idle");
    check_log("reflush", '{8, 16 + 8, 32 + 8, 48 + 8});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
